// File: rtl/cr_prefix_pfsel_pkg.sv
// Shared types for the prefix selector: error code space, FSM states and the
// 9-bit queued result format.
package cr_error_codes;
  typedef enum logic [7:0] {
    NO_ERRORS              = 8'h00,
    CR_ERR_PREFIX_TIMEOUT  = 8'h21,
    CR_ERR_PREFIX_CORRUPT  = 8'h22,
    CR_ERR_PREFIX_OVERFLOW = 8'h33
  } zipline_error_e;
endpackage

package cr_prefixPKG;
  typedef enum logic [1:0] {
    PF_IDLE = 2'd0,
    PF_SCAN = 2'd1,
    PF_WAIT = 2'd2
  } pfsel_state_e;

  // err = 1: payload carries the first error code of the frame.
  // err = 0: payload is {2'b00, prefix_num}.
  typedef struct packed {
    logic       err;
    logic [7:0] payload;
  } pf_result_t;

  localparam pf_result_t PF_NO_PREFIX = 9'd0;
endpackage

// File: rtl/cr_prefix_pfsel_if.sv
// Show-ahead result pop interface between the selector and the output controller.
interface cr_prefix_pfsel_if;
  import cr_prefixPKG::*;

  pf_result_t pf_data;
  logic       pf_empty;
  logic       pf_aempty;
  logic       pf_ren;

  modport master (output pf_data, output pf_empty, output pf_aempty, input pf_ren);
  modport slave  (input pf_data, input pf_empty, input pf_aempty, output pf_ren);
endinterface

// File: rtl/cr_prefix_pfsel_fifo.sv
// Generic show-ahead synchronous FIFO. The head is read straight from the
// storage array so a written entry is visible the cycle after the write.
// A write while full is accepted when a pop happens in the same cycle.
module cr_prefix_pfsel_fifo #(
  parameter int WIDTH         = 9,
  parameter int DEPTH         = 16,
  parameter int AEMPTY_THRESH = 1,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             aempty,
  output logic [AW:0]      count
);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
  localparam logic [AW:0] AE_LVL   = AEMPTY_THRESH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_en;
  logic             wr_en;

  assign rd_en = rd & ~empty;
  assign wr_en = wr & (~full | rd_en);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, data only, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  assign empty  = (count == '0);
  assign full   = (count == FULL_LVL);
  assign aempty = (count <= AE_LVL);
  assign rdata  = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/cr_prefix_pfsel.sv
// Per-frame prefix selector: tracks the best-scoring candidate and the first
// error of each frame, then queues one 9-bit result per frame.
module cr_prefix_pfsel
  import cr_prefixPKG::*;
#(
  parameter int DEPTH         = 16,
  parameter int AEMPTY_THRESH = 1,
  parameter int SCORE_W       = 16,
  parameter int MIN_SCORE     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frm_start,
  input  logic               cand_valid,
  input  logic [5:0]         cand_idx,
  input  logic [SCORE_W-1:0] cand_score,
  input  logic               frm_error,
  input  logic [7:0]         frm_error_code,
  input  logic               frm_done,
  output logic               frm_ready,
  cr_prefix_pfsel_if.master  pf,
  output logic [1:0]         pfsel_stat_events
);
  localparam int                 CW      = $clog2(DEPTH) + 1;
  localparam logic [SCORE_W-1:0] MIN_LVL = SCORE_W'(MIN_SCORE);
  localparam logic [CW-1:0]      CAP     = CW'(DEPTH);

  function automatic pf_result_t encode_result(input logic               err,
                                               input logic [7:0]         code,
                                               input logic [SCORE_W-1:0] score,
                                               input logic [5:0]         idx);
    pf_result_t r;
    if (err) begin
      r.err     = 1'b1;
      r.payload = code;
    end else if (score >= MIN_LVL) begin
      r.err     = 1'b0;
      r.payload = {2'b00, idx};
    end else begin
      r = PF_NO_PREFIX;
    end
    return r;
  endfunction

  pfsel_state_e       state, state_nxt;
  logic [SCORE_W-1:0] best_score, nxt_score;
  logic [5:0]         best_idx, nxt_idx;
  logic               err_flag, nxt_err;
  logic [7:0]         err_code, nxt_code;
  logic               cand_hit;
  logic               push, acc, clear, restart, pop, room;
  pf_result_t         push_res;
  logic               q_full;
  logic [CW-1:0]      q_count;
  logic [1:0]         stat_p1;

  // Candidate/error merge including this cycle's inputs; the strict compare
  // keeps the earliest candidate on a tie.
  assign cand_hit  = cand_valid & (cand_idx != 6'd0) & (cand_score > best_score);
  assign nxt_score = cand_hit ? cand_score : best_score;
  assign nxt_idx   = cand_hit ? cand_idx : best_idx;
  assign nxt_err   = err_flag | frm_error;
  assign nxt_code  = (frm_error & ~err_flag) ? frm_error_code : err_code;

  assign pop       = pf.pf_ren & ~pf.pf_empty;
  assign room      = (q_count < CAP) | pop;
  assign frm_ready = (state != PF_WAIT) & ~((state == PF_SCAN) & q_full);

  // Selector state register.
  always_ff @(posedge clk) begin
    if (rst) state <= PF_IDLE;
    else     state <= state_nxt;
  end

  // Next-state, push request and accumulator control.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    acc       = 1'b0;
    clear     = 1'b0;
    restart   = 1'b0;
    push_res  = encode_result(err_flag, err_code, best_score, best_idx);
    unique case (state)
      PF_IDLE: begin
        if (frm_start) begin
          clear     = 1'b1;
          state_nxt = PF_SCAN;
        end
      end
      PF_SCAN: begin
        push_res = encode_result(nxt_err, nxt_code, nxt_score, nxt_idx);
        if (frm_done) begin
          if (q_full) begin
            // Hold the merged frame result until a slot frees up.
            acc       = 1'b1;
            state_nxt = PF_WAIT;
          end else begin
            push = 1'b1;
            if (frm_start) begin
              clear     = 1'b1;
              state_nxt = PF_SCAN;
            end else begin
              state_nxt = PF_IDLE;
            end
          end
        end else if (frm_start & frm_ready) begin
          clear   = 1'b1;
          restart = 1'b1;
        end else begin
          acc = 1'b1;
        end
      end
      PF_WAIT: begin
        if (room) begin
          push      = 1'b1;
          state_nxt = PF_IDLE;
        end
      end
      default: state_nxt = PF_IDLE;
    endcase
  end

  // Frame accumulator; every frame clears it before use, so no reset.
  always_ff @(posedge clk) begin
    if (clear) begin
      best_score <= '0;
      best_idx   <= '0;
      err_flag   <= 1'b0;
      err_code   <= '0;
    end else if (acc) begin
      best_score <= nxt_score;
      best_idx   <= nxt_idx;
      err_flag   <= nxt_err;
      err_code   <= nxt_code;
    end
  end

  // Event pulses, one cycle after restart / error-result push.
  always_ff @(posedge clk) begin
    if (rst) stat_p1 <= 2'b00;
    else     stat_p1 <= {push & push_res.err, restart};
  end

  assign pfsel_stat_events = stat_p1;

  cr_prefix_pfsel_fifo #(
    .WIDTH         ($bits(pf_result_t)),
    .DEPTH         (DEPTH),
    .AEMPTY_THRESH (AEMPTY_THRESH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr     (push),
    .wdata  (push_res),
    .rd     (pf.pf_ren),
    .rdata  (pf.pf_data),
    .full   (q_full),
    .empty  (pf.pf_empty),
    .aempty (pf.pf_aempty),
    .count  (q_count)
  );
endmodule
